mem_port_arbiter: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/arb_lat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory-side blocks.
// Holds the arbiter FSM encoding and the default bus widths.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter for fixed-latency operations.
// Flags the last busy cycle (cnt==1) and completion (cnt==0).
module arb_lat_counter #(
  parameter int LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last,
  output logic done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(LOAD_VAL);
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign last = (cnt == 4'd1);
  assign done = (cnt == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF-stage fetches and MEM-stage data accesses onto one
// fixed-latency single-port RAM; data wins, bounded by a streak limit.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  // Handshake: a requester holds its req (and address/data) until its
  // one-cycle ready strobe; the request is sampled only at the grant edge.
  arb_state_t state, state_nxt;
  logic [3:0] streak;
  logic       abort_pend;
  logic       grant_d, grant_i;
  logic       cnt_last, cnt_done;
  logic       dm_req;

  assign dm_req = dm_rd | dm_wr;

  arb_lat_counter #(
    .LOAD_VAL(MEM_LAT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(grant_d | grant_i),
    .dec (state != IDLE),
    .last(cnt_last),
    .done(cnt_done)
  );

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (!if_req || (streak < STREAK_MAX))) begin
          state_nxt = WAIT_D;
          grant_d   = 1'b1;
        end else if (if_req) begin
          state_nxt = WAIT_I;
          grant_i   = 1'b1;
        end
      end
      WAIT_I, WAIT_D: begin
        if (cnt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      streak     <= 4'd0;
      abort_pend <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ram_en <= grant_d | grant_i;
      ram_we <= grant_d & dm_wr;
      if (grant_d) begin
        ram_addr  <= dm_addr;
        ram_wdata <= dm_wdata;
        streak    <= if_req ? (streak + 4'd1) : 4'd0;
      end else if (grant_i) begin
        ram_addr <= if_addr;
        streak   <= 4'd0;
      end
      // A flush arriving on the final busy cycle must still swallow the strobe.
      if_ready   <= (state == WAIT_I) && cnt_last && !abort_pend && !if_abort;
      dm_ready   <= (state == WAIT_D) && cnt_last;
      abort_pend <= (state == WAIT_I) && !cnt_done && (abort_pend || if_abort);
    end
  end

  assign if_rdata = if_ready ? ram_rdata : '0;
  assign dm_rdata = dm_ready ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, MAX_DSTREAK=3) with a
// small RAM model returning addr^KEY two cycles after each ram_en.
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, dm_rd, dm_wr;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ready, dm_ready, ram_en, ram_we;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata, ram_rdata;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DSTREAK(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Two-stage RAM read pipe: data valid MEM_LAT=2 cycles after ram_en.
  logic        v1, v2;
  logic [31:0] a1, a2;
  always @(posedge clk) begin
    v1 <= ram_en; a1 <= ram_addr;
    v2 <= v1;     a2 <= a1;
  end
  assign ram_rdata = (v2 === 1'b1) ? (a2 ^ KEY) : 32'h0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_abort = 0; dm_rd = 0; dm_wr = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    step(); step();
    n_cmp++;
    if ({ram_en, ram_we, if_ready, dm_ready} !== 4'b0 || ram_addr !== 0 || ram_wdata !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs got en=%0b we=%0b ir=%0b dr=%0b addr=%h wd=%h exp all 0",
               ram_en, ram_we, if_ready, dm_ready, ram_addr, ram_wdata);
    end
    n_cmp++;
    if (dut.state !== IDLE || dut.streak !== 4'd0 || dut.abort_pend !== 1'b0 || dut.u_cnt.cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got state=%0d streak=%0d ap=%0b cnt=%0d exp 0/0/0/0",
               dut.state, dut.streak, dut.abort_pend, dut.u_cnt.cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (ram_en !== (k == 1)) begin
        n_fail++; $display("FAIL fetch_ram_en cyc%0d got %0b exp %0b", k, ram_en, k == 1);
      end
      n_cmp++;
      if (if_ready !== (k == 3) || dm_ready !== 1'b0) begin
        n_fail++; $display("FAIL fetch_ready cyc%0d got ir=%0b dr=%0b exp ir=%0b dr=0", k, if_ready, dm_ready, k == 3);
      end
      if (k == 1) begin
        n_cmp++;
        if (ram_we !== 1'b0 || ram_addr !== 32'h40) begin
          n_fail++; $display("FAIL fetch_addr got we=%0b addr=%h exp we=0 addr=00000040", ram_we, ram_addr);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (if_rdata !== (32'h40 ^ KEY)) begin
          n_fail++; $display("FAIL fetch_rdata got %h exp %h", if_rdata, 32'h40 ^ KEY);
        end
        if_req = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h80; dm_rd = 1; dm_addr = 32'h100;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (ram_en !== (k == 1 || k == 5)) begin
        n_fail++; $display("FAIL simul_ram_en cyc%0d got %0b exp %0b", k, ram_en, k == 1 || k == 5);
      end
      n_cmp++;
      if (dm_ready !== (k == 3) || if_ready !== (k == 7)) begin
        n_fail++; $display("FAIL simul_ready cyc%0d got dr=%0b ir=%0b exp dr=%0b ir=%0b",
                           k, dm_ready, if_ready, k == 3, k == 7);
      end
      if (k == 1 || k == 5) begin
        n_cmp++;
        if (ram_addr !== ((k == 1) ? 32'h100 : 32'h80)) begin
          n_fail++; $display("FAIL simul_addr cyc%0d got %h exp %h", k, ram_addr, (k == 1) ? 32'h100 : 32'h80);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (dm_rdata !== (32'h100 ^ KEY) || if_rdata !== 32'h0) begin
          n_fail++; $display("FAIL simul_dm_rdata got dm=%h if=%h exp dm=%h if=0", dm_rdata, if_rdata, 32'h100 ^ KEY);
        end
        dm_rd = 0;
      end
      if (k == 7) if_req = 0;
    end
  endtask

  task automatic test_streak();
    string order = "";
    int    n = 0;
    int    first_i = -1;
    int    last_k = -1;
    dm_rd = 1; dm_addr = 32'h500; if_req = 1; if_addr = 32'h600;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (dm_ready === 1'b1) begin order = {order, "D"}; n++; last_k = k; end
      if (if_ready === 1'b1) begin
        order = {order, "I"}; n++; last_k = k;
        if (first_i < 0) begin
          first_i = k;
          n_cmp++;
          if (if_rdata !== (32'h600 ^ KEY)) begin
            n_fail++; $display("FAIL streak_if_rdata got %h exp %h", if_rdata, 32'h600 ^ KEY);
          end
        end
      end
      if (n >= 5) break;
    end
    dm_rd = 0; if_req = 0;
    n_cmp++;
    if (order != "DDDID") begin
      n_fail++; $display("FAIL streak_order got %s exp DDDID", order);
    end
    n_cmp++;
    if (first_i != 15 || last_k != 19) begin
      n_fail++; $display("FAIL streak_timing got first_i=%0d last=%0d exp 15/19", first_i, last_k);
    end
    step();
  endtask

  task automatic test_store();
    dm_wr = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (ram_en !== (k == 1) || dm_ready !== (k == 3) || if_ready !== 1'b0) begin
        n_fail++; $display("FAIL store_seq cyc%0d got en=%0b dr=%0b ir=%0b exp en=%0b dr=%0b ir=0",
                           k, ram_en, dm_ready, if_ready, k == 1, k == 3);
      end
      if (k == 1) begin
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 32'h200 || ram_wdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL store_bus got we=%0b addr=%h wd=%h exp we=1 addr=00000200 wd=deadbeef",
                             ram_we, ram_addr, ram_wdata);
        end
      end
      if (k == 3) dm_wr = 0;
    end
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h300;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin if_abort = 1; if_req = 0; end
      if (k == 2) if_abort = 0;
      n_cmp++;
      if (ram_en !== (k == 1 || k == 5)) begin
        n_fail++; $display("FAIL flush_ram_en cyc%0d got %0b exp %0b", k, ram_en, k == 1 || k == 5);
      end
      n_cmp++;
      if (if_ready !== (k == 7)) begin
        n_fail++; $display("FAIL flush_if_ready cyc%0d got %0b exp %0b", k, if_ready, k == 7);
      end
      if (k == 4) begin if_req = 1; if_addr = 32'h304; end
      if (k == 7) begin
        n_cmp++;
        if (if_rdata !== (32'h304 ^ KEY)) begin
          n_fail++; $display("FAIL flush_refetch_rdata got %h exp %h", if_rdata, 32'h304 ^ KEY);
        end
        if_req = 0;
      end
    end
  endtask

  task automatic test_reset_mid();
    dm_rd = 1; dm_addr = 32'h400;
    step();
    step();
    rst = 1; dm_rd = 0;
    step();
    n_cmp++;
    if ({ram_en, ram_we, if_ready, dm_ready} !== 4'b0 || ram_addr !== 0 || ram_wdata !== 0 ||
        dm_rdata !== 0 || if_rdata !== 0) begin
      n_fail++; $display("FAIL rstmid_outputs got en=%0b we=%0b ir=%0b dr=%0b addr=%h wd=%h dmr=%h exp all 0",
                         ram_en, ram_we, if_ready, dm_ready, ram_addr, ram_wdata, dm_rdata);
    end
    n_cmp++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL rstmid_state got %0d exp 0", dut.state);
    end
    rst = 0;
    for (int k = 4; k <= 7; k++) begin
      step();
      n_cmp++;
      if (dm_ready !== 1'b0 || ram_en !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_quiet cyc%0d got dr=%0b en=%0b exp 0/0", k, dm_ready, ram_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    step();
    test_simultaneous();
    step();
    test_streak();
    test_store();
    step();
    test_flush();
    step();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
